video_seq_ctrl: RTL and testbench
=================================

# video_seq_ctrl

Sequencer for the VGA test-pattern datapath. It sits between the PLL, the user button, the pattern generator, the pixel FIFO and the VGA transmitter. It brings the pipeline up only after PLL lock and a FIFO prefill, and applies pattern changes only at frame boundaries. It also detects FIFO underflow and restarts the pipeline frame-aligned.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 65536: cycles the synchronized button must be stable (pressed) to register one press.
- FLUSH_CYCLES, 16: cycles the FLUSH state holds generator reset and FIFO flush.
- N_PATTERNS, 4: number of test patterns; pattern index wraps at N_PATTERNS-1.
- PW, 2: pattern index width; must satisfy 2^PW >= N_PATTERNS.

Ports:
- clk, input, 1: pixel clock (PLL output).
- rst_n, input, 1: asynchronous, active-low reset.
- pll_locked, input, 1: PLL lock; asynchronous, synchronized internally.
- button_n, input, 1: raw push button, low = pressed; asynchronous.
- fifo_empty, input, 1: pixel FIFO empty.
- fifo_almost_full, input, 1: pixel FIFO above high-water mark.
- fetch, input, 1: transmitter pixel-fetch strobe.
- frame_start, input, 1: one-cycle pulse from the transmitter at the first active pixel of a frame.
- pattern, output, PW: pattern index applied to the generator.
- gen_rst, output, 1: generator reset (restart at pixel 0,0).
- gen_cke, output, 1: generator clock enable.
- fifo_flush, output, 1: synchronous FIFO clear.
- tx_en, output, 1: transmitter enable; low holds the transmitter at frame origin.
- underflow_cnt, output, 8: saturating underflow count.
- state, output, 2: current FSM state, for LEDs.

## Operation

- Two-flop synchronizers on pll_locked and button_n.
- Debounce counter: reloads on any change of the synchronized button. It emits one press pulse when the pressed level has been stable for DEBOUNCE_CYCLES. A release must also be stable for DEBOUNCE_CYCLES before another press is accepted.
- pending_pattern:
  - Each press increments it, wrapping N_PATTERNS-1 to 0.
  - pending flag is set whenever pending_pattern != pattern.
- FSM states (encoding in package):
  - WAIT_LOCK (0): gen_rst=1, gen_cke=0, tx_en=0, fifo_flush=0. Goes to FLUSH once synced lock=1.
  - FLUSH (1): gen_rst=1, fifo_flush=1, tx_en=0, gen_cke=0. On entry, pattern <= pending_pattern. Goes to PREFILL after FLUSH_CYCLES cycles.
  - PREFILL (2): gen_rst=0, gen_cke=~fifo_almost_full, tx_en=0. Goes to RUN on the first cycle with fifo_almost_full=1.
  - RUN (3): gen_cke=~fifo_almost_full, tx_en=1. Goes to FLUSH on:
    - a frame_start while pending is set, or
    - an underflow (fetch=1 and fifo_empty=1 in the same cycle).
- Synced lock=0 in any state: next state is WAIT_LOCK. This has priority over all other transitions.
- Underflow event increments underflow_cnt, saturating at 255. Underflow outside RUN is ignored.

## Timing

- Reset values:
  - pattern=0, pending_pattern=0.
  - gen_rst=1, gen_cke=0, fifo_flush=0, tx_en=0.
  - underflow_cnt=0, state=WAIT_LOCK.
  - Debounce counter cleared.
- All outputs are registered.
- Lock assertion to FLUSH: 3 cycles (2 sync + 1).
- Lock loss to WAIT_LOCK outputs: 3 cycles. pattern, pending_pattern and underflow_cnt are retained.
- Underflow:
  - tx_en falls the cycle after the offending fetch.
  - The counter updates in that same cycle.
- Pattern change: takes effect the cycle after the first frame_start following the press. No change occurs mid-frame.
- Presses during FLUSH or PREFILL update pending_pattern. Pending is re-evaluated in RUN.
- frame_start and underflow in the same cycle produce one FLUSH entry. The counter increments and the pending pattern is applied.
- Press pulse and FLUSH entry in the same cycle: the FLUSH entry loads the pre-increment value and pending stays set.

## Configuration

- VIDEO_SEQ_UNDERFLOW_CNT_EN defined: underflow_cnt is implemented as above.
- Not defined: underflow_cnt is tied to 0 and its register is removed.
- Underflow detection and resync apply in both cases.

## Structure

- Package video_seq_pkg holds:
  - the state encoding (WAIT_LOCK=0, FLUSH=1, PREFILL=2, RUN=3);
  - the counter width constant (8).
- One sub-module, button_debounce: synchronizer plus debounce counter, outputting a one-cycle press pulse.
- The FSM, pattern registers and underflow counter stay in the top.

## Test plan

- Reset release with pll_locked=0 → state=0, gen_rst=1, tx_en=0. Raise lock → state=1 exactly 3 cycles later; held 16 cycles; then state=2.
- PREFILL, assert fifo_almost_full → next cycle state=3, tx_en=1, gen_cke=0. Deassert → gen_cke=1 next cycle.
- With DEBOUNCE_CYCLES=8: a 5-cycle button glitch → no change. Stable press for 20 cycles → pending_pattern=1; pattern stays 0 until frame_start, then pattern=1, state=1.
- 4 debounced presses before frame_start starting at pattern 3 → pending wraps to 3; no FLUSH at frame_start (pending clear).
- RUN with fetch=1 and fifo_empty=1 → tx_en=0 and underflow_cnt=1 next cycle. 300 underflow events → count 255 (macro defined) or 0 (undefined).
- Drop pll_locked in RUN → state=0 within 3 cycles; pattern retained. Assert rst_n low mid-FLUSH → all outputs at reset values immediately.

Source files
------------

// File: rtl/video_seq_pkg.sv
// Shared types and constants for the VGA test-pattern sequencer.
package video_seq_pkg;

   localparam int unsigned UCNT_W = 8;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_FLUSH     = 2'd1,
      ST_PREFILL   = 2'd2,
      ST_RUN       = 2'd3
   } state_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer and debounce for an active-low push button.
// Emits a one-cycle press pulse once a new pressed level has been stable.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_button_n,
   output logic o_press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    r_sync;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_press;
   logic          w_pressed;

   assign w_pressed = ~r_sync[1];

   // Counter runs only while the synced level differs from the accepted level;
   // any bounce back to the accepted level reloads it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= 2'b11;
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_button_n};
         r_press <= 1'b0;
         if (w_pressed == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_level <= w_pressed;
            r_press <= w_pressed;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/video_seq_ctrl.sv
// Bring-up / frame-aligned pattern sequencer for the VGA test-pattern path.
// Define VIDEO_SEQ_UNDERFLOW_CNT_EN to implement the saturating underflow counter.
module video_seq_ctrl
   import video_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 65536,
   parameter int unsigned FLUSH_CYCLES    = 16,
   parameter int unsigned N_PATTERNS      = 4,
   parameter int unsigned PW              = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pll_locked,
   input  logic              button_n,
   input  logic              fifo_empty,
   input  logic              fifo_almost_full,
   input  logic              fetch,
   input  logic              frame_start,
   output logic [PW-1:0]     pattern,
   output logic              gen_rst,
   output logic              gen_cke,
   output logic              fifo_flush,
   output logic              tx_en,
   output logic [UCNT_W-1:0] underflow_cnt,
   output logic [1:0]        state
);

   localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);

   logic [1:0]     r_lock_sync;
   logic           w_lock;
   logic           w_press;
   state_e         r_state;
   state_e         w_state_nxt;
   logic [FCW-1:0] r_flush_cnt;
   logic [PW-1:0]  r_pattern;
   logic [PW-1:0]  r_pending_pattern;
   logic           w_pending;
   logic           w_underflow;
   logic           r_gen_rst, r_gen_cke, r_fifo_flush, r_tx_en;
   logic           w_gen_rst_nxt, w_gen_cke_nxt, w_fifo_flush_nxt, w_tx_en_nxt;

   function automatic logic [PW-1:0] f_next_pattern(input logic [PW-1:0] p);
      return (p == PW'(N_PATTERNS - 1)) ? '0 : p + PW'(1);
   endfunction

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_button_n (button_n),
      .o_press    (w_press)
   );

   assign w_lock      = r_lock_sync[1];
   assign w_pending   = (r_pending_pattern != r_pattern);
   assign w_underflow = (r_state == ST_RUN) && fetch && fifo_empty;

   // Next state, then the registered outputs decoded from that next state.
   always_comb begin
      w_state_nxt      = r_state;
      w_gen_rst_nxt    = 1'b1;
      w_gen_cke_nxt    = 1'b0;
      w_fifo_flush_nxt = 1'b0;
      w_tx_en_nxt      = 1'b0;
      case (r_state)
         ST_WAIT_LOCK: if (w_lock) w_state_nxt = ST_FLUSH;
         ST_FLUSH:     if (r_flush_cnt == FCW'(FLUSH_CYCLES - 1)) w_state_nxt = ST_PREFILL;
         ST_PREFILL:   if (fifo_almost_full) w_state_nxt = ST_RUN;
         ST_RUN:       if (w_underflow || (frame_start && w_pending)) w_state_nxt = ST_FLUSH;
         default:      w_state_nxt = ST_WAIT_LOCK;
      endcase
      if (!w_lock) w_state_nxt = ST_WAIT_LOCK;
      case (w_state_nxt)
         ST_FLUSH:   w_fifo_flush_nxt = 1'b1;
         ST_PREFILL: begin
            w_gen_rst_nxt = 1'b0;
            w_gen_cke_nxt = ~fifo_almost_full;
         end
         ST_RUN: begin
            w_gen_rst_nxt = 1'b0;
            w_gen_cke_nxt = ~fifo_almost_full;
            w_tx_en_nxt   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_sync       <= 2'b00;
         r_state           <= ST_WAIT_LOCK;
         r_flush_cnt       <= '0;
         r_pattern         <= '0;
         r_pending_pattern <= '0;
         r_gen_rst         <= 1'b1;
         r_gen_cke         <= 1'b0;
         r_fifo_flush      <= 1'b0;
         r_tx_en           <= 1'b0;
      end else begin
         r_lock_sync  <= {r_lock_sync[0], pll_locked};
         r_state      <= w_state_nxt;
         r_gen_rst    <= w_gen_rst_nxt;
         r_gen_cke    <= w_gen_cke_nxt;
         r_fifo_flush <= w_fifo_flush_nxt;
         r_tx_en      <= w_tx_en_nxt;
         r_flush_cnt  <= ((r_state == ST_FLUSH) && (w_state_nxt == ST_FLUSH))
                         ? r_flush_cnt + FCW'(1) : '0;
         // FLUSH entry latches the pre-increment pending value if a press coincides.
         if ((w_state_nxt == ST_FLUSH) && (r_state != ST_FLUSH))
            r_pattern <= r_pending_pattern;
         if (w_press)
            r_pending_pattern <= f_next_pattern(r_pending_pattern);
      end
   end

`ifdef VIDEO_SEQ_UNDERFLOW_CNT_EN
   logic [UCNT_W-1:0] r_underflow_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_underflow_cnt <= '0;
      else if (w_underflow && (r_underflow_cnt != '1))
         r_underflow_cnt <= r_underflow_cnt + UCNT_W'(1);
   end

   assign underflow_cnt = r_underflow_cnt;
`else
   assign underflow_cnt = '0;
`endif

   assign pattern    = r_pattern;
   assign gen_rst    = r_gen_rst;
   assign gen_cke    = r_gen_cke;
   assign fifo_flush = r_fifo_flush;
   assign tx_en      = r_tx_en;
   assign state      = r_state;

endmodule

// File: tb/tb_video_seq_ctrl.sv
// Directed self-checking bench for video_seq_ctrl (DEBOUNCE_CYCLES=8).
module tb_video_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, pll_locked, button_n, fifo_empty, fifo_almost_full, fetch, frame_start;
   logic [1:0] pattern;
   logic       gen_rst, gen_cke, fifo_flush, tx_en;
   logic [7:0] underflow_cnt;
   logic [1:0] state;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   video_seq_ctrl #(
      .DEBOUNCE_CYCLES (8),
      .FLUSH_CYCLES    (16),
      .N_PATTERNS      (4),
      .PW              (2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pll_locked       (pll_locked),
      .button_n         (button_n),
      .fifo_empty       (fifo_empty),
      .fifo_almost_full (fifo_almost_full),
      .fetch            (fetch),
      .frame_start      (frame_start),
      .pattern          (pattern),
      .gen_rst          (gen_rst),
      .gen_cke          (gen_cke),
      .fifo_flush       (fifo_flush),
      .tx_en            (tx_en),
      .underflow_cnt    (underflow_cnt),
      .state            (state)
   );

   always #5 clk = ~clk;

   function automatic int unsigned exp_ucnt(input int unsigned n);
`ifdef VIDEO_SEQ_UNDERFLOW_CNT_EN
      return (n > 255) ? 255 : n;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input string tag, input int unsigned exp, input int unsigned budget);
      int unsigned k = 0;
      while (32'(state) != exp && k < budget) begin
         tick();
         k++;
      end
      check(tag, 32'(state), exp);
   endtask

   task automatic press();
      button_n = 1'b0;
      repeat (20) tick();
      button_n = 1'b1;
      repeat (20) tick();
   endtask

   task automatic bring_to_run(input string tag);
      wait_state(tag, 2, 40);
      fifo_almost_full = 1'b1;
      tick();
      check({tag, "_run"}, 32'(state), 3);
      fifo_almost_full = 1'b0;
      tick();
   endtask

   task automatic frame_pulse();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      int unsigned total;
      int unsigned guard;
      logic [1:0]  prev_st;

      rst_n = 1'b0; pll_locked = 1'b0; button_n = 1'b1; fifo_empty = 1'b0;
      fifo_almost_full = 1'b0; fetch = 1'b0; frame_start = 1'b0;
      repeat (3) tick();
      check("rst_state", 32'(state), 0);
      check("rst_gen_rst", 32'(gen_rst), 1);
      check("rst_tx_en", 32'(tx_en), 0);
      check("rst_pattern", 32'(pattern), 0);
      check("rst_ucnt", 32'(underflow_cnt), 0);
      rst_n = 1'b1;
      repeat (4) tick();
      check("nolock_state", 32'(state), 0);

      // Lock bring-up latency and FLUSH length
      pll_locked = 1'b1;
      repeat (2) tick();
      check("lock_lat2", 32'(state), 0);
      tick();
      check("lock_lat3", 32'(state), 1);
      check("flush_on", 32'(fifo_flush), 1);
      repeat (15) tick();
      check("flush_held", 32'(state), 1);
      tick();
      check("prefill_state", 32'(state), 2);
      check("prefill_gen_rst", 32'(gen_rst), 0);
      check("prefill_cke", 32'(gen_cke), 1);
      check("prefill_flush", 32'(fifo_flush), 0);

      fifo_almost_full = 1'b1;
      tick();
      check("run_state", 32'(state), 3);
      check("run_tx_en", 32'(tx_en), 1);
      check("run_cke_full", 32'(gen_cke), 0);
      fifo_almost_full = 1'b0;
      tick();
      check("run_cke_free", 32'(gen_cke), 1);

      // Short glitch must not register
      button_n = 1'b0;
      repeat (5) tick();
      button_n = 1'b1;
      repeat (20) tick();
      frame_pulse();
      check("glitch_state", 32'(state), 3);
      check("glitch_pattern", 32'(pattern), 0);

      // Real press applied only at frame_start
      press();
      check("press_midframe", 32'(pattern), 0);
      check("press_midframe_st", 32'(state), 3);
      frame_pulse();
      check("press_apply_st", 32'(state), 1);
      check("press_apply_pat", 32'(pattern), 1);
      bring_to_run("p1");
      press();
      frame_pulse();
      check("pat2", 32'(pattern), 2);
      bring_to_run("p2");
      press();
      frame_pulse();
      check("pat3", 32'(pattern), 3);
      bring_to_run("p3");

      // Four presses wrap pending back to the applied pattern
      repeat (4) press();
      frame_pulse();
      check("wrap_state", 32'(state), 3);
      check("wrap_pattern", 32'(pattern), 3);

      // Single underflow
      fetch = 1'b1; fifo_empty = 1'b1;
      tick();
      fetch = 1'b0; fifo_empty = 1'b0;
      check("uf_tx_en", 32'(tx_en), 0);
      check("uf_state", 32'(state), 1);
      check("uf_cnt1", 32'(underflow_cnt), exp_ucnt(1));
      bring_to_run("uf1");

      // frame_start and underflow together: one FLUSH, pattern applied, count bumps
      press();
      frame_start = 1'b1; fetch = 1'b1; fifo_empty = 1'b1;
      tick();
      frame_start = 1'b0;
      check("both_state", 32'(state), 1);
      check("both_pattern", 32'(pattern), 0);
      check("both_cnt", 32'(underflow_cnt), exp_ucnt(2));

      // Repeated underflows up to 300 total
      fifo_almost_full = 1'b1;
      total = 2; guard = 0; prev_st = state;
      while (total < 300 && guard < 20000) begin
         tick();
         guard++;
         if (prev_st == 2'd3) begin
            total++;
            if (total == 10) check("uf_cnt10", 32'(underflow_cnt), exp_ucnt(10));
         end
         prev_st = state;
      end
      fetch = 1'b0; fifo_empty = 1'b0;
      check("uf_loop_events", total, 300);
      check("uf_sat", 32'(underflow_cnt), exp_ucnt(300));
      wait_state("uf_recover", 3, 40);
      fifo_almost_full = 1'b0;
      tick();

      press();
      frame_pulse();
      check("pat1_again", 32'(pattern), 1);
      bring_to_run("p4");

      // Lock loss: 3-cycle latency, state retained
      pll_locked = 1'b0;
      repeat (2) tick();
      check("unlock_lat2", 32'(state), 3);
      tick();
      check("unlock_state", 32'(state), 0);
      check("unlock_tx_en", 32'(tx_en), 0);
      check("unlock_gen_rst", 32'(gen_rst), 1);
      check("unlock_pattern", 32'(pattern), 1);
      check("unlock_cnt", 32'(underflow_cnt), exp_ucnt(300));

      // Async reset mid-FLUSH
      pll_locked = 1'b1;
      repeat (3) tick();
      check("relock_state", 32'(state), 1);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("arst_state", 32'(state), 0);
      check("arst_gen_rst", 32'(gen_rst), 1);
      check("arst_flush", 32'(fifo_flush), 0);
      check("arst_pattern", 32'(pattern), 0);
      check("arst_cnt", 32'(underflow_cnt), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
